// File: rtl/keypad_pkg.sv
// Shared FSM state type, key-code map and column priority helper for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_e;

    // Indexed by {row, col}; entry 0 is row0/col0.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [1:0] first_col(input logic [3:0] cols);
        logic [1:0] idx;
        casez (cols)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle: row drives, column senses and the accepted-key event.
interface keypad_scanner_if;
    import keypad_pkg::*;

    wire  [3:0] rows;
    logic [3:0] cols;
    wire  [3:0] key;
    wire        key_valid;

    modport master (output rows, output key, output key_valid, input cols);
    modport slave  (input rows, input key, input key_valid, output cols);

endinterface

// File: rtl/keypad_keymap.sv
// Combinational translation of a latched row/column position into its key code.
module keypad_keymap
    import keypad_pkg::*;
(
    input  logic [1:0] i_row,
    input  logic [1:0] i_col,
    output logic [3:0] o_code
);

    assign o_code = KEY_MAP[{i_row, i_col}];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates row drives, latches the first hit, debounces press and release
// on the latched column only, and pulses key_valid once per accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       C0,
    input  logic       C1,
    input  logic       C2,
    input  logic       C3,
    output logic       R0,
    output logic       R1,
    output logic       R2,
    output logic       R3,
    output logic [3:0] key,
    output logic       key_valid
);

    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
    localparam logic [SCAN_W-1:0] SCAN_ZERO = SCAN_W'(0);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_ZERO   = DB_W'(0);

    state_e            r_state;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [DB_W-1:0]   r_db_cnt;
    logic [1:0]        r_row;
    logic [1:0]        r_col;
    logic [3:0]        r_rows;
    logic [3:0]        r_key;
    logic              r_key_valid;

    logic [3:0]        w_cols;
    logic              w_col_hi;
    logic [3:0]        w_code;

    assign w_cols   = {C3, C2, C1, C0};
    assign w_col_hi = w_cols[r_col];

    keypad_keymap u_keymap (
        .i_row  (r_row),
        .i_col  (r_col),
        .o_code (w_code)
    );

    // Scan / debounce FSM; row drive stays frozen from the latching sample until release completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_SCAN;
            r_scan_cnt  <= SCAN_ZERO;
            r_db_cnt    <= DB_ZERO;
            r_row       <= 2'd0;
            r_col       <= 2'd0;
            r_rows      <= 4'b0001;
            r_key       <= 4'h0;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if (r_scan_cnt == SCAN_LAST) begin
                        r_scan_cnt <= SCAN_ZERO;
                        if (|w_cols) begin
                            r_state  <= ST_PRESS_DB;
                            r_col    <= first_col(w_cols);
                            r_db_cnt <= DB_ZERO;
                        end else begin
                            r_row  <= r_row + 2'd1;
                            r_rows <= {r_rows[2:0], r_rows[3]};
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + SCAN_ONE;
                    end
                end
                ST_PRESS_DB: begin
                    if (!w_col_hi) begin
                        r_state  <= ST_SCAN;
                        r_db_cnt <= DB_ZERO;
                        r_row    <= r_row + 2'd1;
                        r_rows   <= {r_rows[2:0], r_rows[3]};
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state     <= ST_HELD;
                        r_db_cnt    <= DB_ZERO;
                        r_key       <= w_code;
                        r_key_valid <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_ONE;
                    end
                end
                ST_HELD: begin
                    if (!w_col_hi) begin
                        r_state  <= ST_RELEASE_DB;
                        r_db_cnt <= DB_ZERO;
                    end else begin
                        r_state <= ST_HELD;
                    end
                end
                ST_RELEASE_DB: begin
                    if (w_col_hi) begin
                        r_db_cnt <= DB_ZERO;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state  <= ST_SCAN;
                        r_db_cnt <= DB_ZERO;
                        r_row    <= r_row + 2'd1;
                        r_rows   <= {r_rows[2:0], r_rows[3]};
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_ONE;
                    end
                end
                default: begin
                    r_state    <= ST_SCAN;
                    r_scan_cnt <= SCAN_ZERO;
                    r_db_cnt   <= DB_ZERO;
                    r_row      <= 2'd0;
                    r_rows     <= 4'b0001;
                end
            endcase
        end
    end

    assign R0        = r_rows[0];
    assign R1        = r_rows[1];
    assign R2        = r_rows[2];
    assign R3        = r_rows[3];
    assign key       = r_key;
    assign key_valid = r_key_valid;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_CYCLES=4, DEBOUNCE_CYCLES=8.
module tb_keypad_scanner;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   pulses = 0;
    int   p0;

    keypad_scanner_if u_if ();

    keypad_scanner #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .C0        (u_if.cols[0]),
        .C1        (u_if.cols[1]),
        .C2        (u_if.cols[2]),
        .C3        (u_if.cols[3]),
        .R0        (u_if.rows[0]),
        .R1        (u_if.rows[1]),
        .R2        (u_if.rows[2]),
        .R3        (u_if.rows[3]),
        .key       (u_if.key),
        .key_valid (u_if.key_valid)
    );

    always #5 clk = ~clk;

    // Counts every cycle key_valid is high, sampled just after the active edge.
    always @(posedge clk) begin
        #2;
        if (u_if.key_valid === 1'b1) pulses = pulses + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        u_if.cols = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_rows", {28'd0, u_if.rows}, 32'h1);
        chk("rst_key", {28'd0, u_if.key}, 32'h0);
        chk("rst_kv", {31'd0, u_if.key_valid}, 32'h0);

        // Idle rotation
        reset = 1'b1;
        p0 = pulses;
        step(3);
        chk("idle_r0_hold", {28'd0, u_if.rows}, 32'h1);
        step(1);
        chk("idle_r1", {28'd0, u_if.rows}, 32'h2);
        step(4);
        chk("idle_r2", {28'd0, u_if.rows}, 32'h4);
        step(4);
        chk("idle_r3", {28'd0, u_if.rows}, 32'h8);
        step(4);
        chk("idle_wrap_r0", {28'd0, u_if.rows}, 32'h1);
        chk("idle_key", {28'd0, u_if.key}, 32'h0);
        chk("idle_pulses", pulses - p0, 32'd0);

        // Key 5: C1 on R1
        step(4);
        chk("k5_on_r1", {28'd0, u_if.rows}, 32'h2);
        p0 = pulses;
        u_if.cols = 4'b0010;
        step(4);
        chk("k5_frozen", {28'd0, u_if.rows}, 32'h2);
        step(7);
        chk("k5_kv_early", {31'd0, u_if.key_valid}, 32'h0);
        step(1);
        chk("k5_kv", {31'd0, u_if.key_valid}, 32'h1);
        chk("k5_key", {28'd0, u_if.key}, 32'h5);
        step(1);
        chk("k5_kv_drop", {31'd0, u_if.key_valid}, 32'h0);
        u_if.cols = 4'b1011;
        step(5);
        chk("k5_held_rows", {28'd0, u_if.rows}, 32'h2);
        u_if.cols = 4'b0000;
        step(8);
        chk("k5_rel_rows", {28'd0, u_if.rows}, 32'h2);
        step(1);
        chk("k5_resume_r2", {28'd0, u_if.rows}, 32'h4);
        chk("k5_pulses", pulses - p0, 32'd1);

        // Short C3 glitch on R2
        p0 = pulses;
        step(1);
        u_if.cols = 4'b1000;
        step(3);
        chk("gl_frozen", {28'd0, u_if.rows}, 32'h4);
        u_if.cols = 4'b0000;
        step(1);
        chk("gl_resume_r3", {28'd0, u_if.rows}, 32'h8);
        chk("gl_key", {28'd0, u_if.key}, 32'h5);
        chk("gl_pulses", pulses - p0, 32'd0);

        // C0 and C2 on R3 -> E
        p0 = pulses;
        u_if.cols = 4'b0101;
        step(11);
        chk("ke_kv_early", {31'd0, u_if.key_valid}, 32'h0);
        step(1);
        chk("ke_kv", {31'd0, u_if.key_valid}, 32'h1);
        chk("ke_key", {28'd0, u_if.key}, 32'hE);
        step(1);
        chk("ke_kv_drop", {31'd0, u_if.key_valid}, 32'h0);
        u_if.cols = 4'b0000;
        step(9);
        chk("ke_resume_r0", {28'd0, u_if.rows}, 32'h1);
        chk("ke_pulses", pulses - p0, 32'd1);

        // Key 9 with release bounce
        step(8);
        chk("k9_on_r2", {28'd0, u_if.rows}, 32'h4);
        p0 = pulses;
        u_if.cols = 4'b0100;
        step(12);
        chk("k9_kv", {31'd0, u_if.key_valid}, 32'h1);
        chk("k9_key", {28'd0, u_if.key}, 32'h9);
        step(1);
        u_if.cols = 4'b0000;
        step(1);
        u_if.cols = 4'b0100;
        step(1);
        u_if.cols = 4'b0000;
        step(7);
        chk("k9_bounce_rows", {28'd0, u_if.rows}, 32'h4);
        step(1);
        chk("k9_resume_r3", {28'd0, u_if.rows}, 32'h8);
        chk("k9_pulses", pulses - p0, 32'd1);
        chk("k9_key_hold", {28'd0, u_if.key}, 32'h9);

        // Reset mid press-debounce on R0/C1
        step(4);
        chk("rd_on_r0", {28'd0, u_if.rows}, 32'h1);
        p0 = pulses;
        u_if.cols = 4'b0010;
        step(7);
        reset = 1'b0;
        #1;
        chk("rd_rows", {28'd0, u_if.rows}, 32'h1);
        chk("rd_key", {28'd0, u_if.key}, 32'h0);
        chk("rd_kv", {31'd0, u_if.key_valid}, 32'h0);
        step(10);
        u_if.cols = 4'b0000;
        reset = 1'b1;
        step(3);
        chk("rd_first_r0", {28'd0, u_if.rows}, 32'h1);
        step(1);
        chk("rd_first_r1", {28'd0, u_if.rows}, 32'h2);
        chk("rd_pulses", pulses - p0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
